spi_display_sequencer: RTL

Parametrised instruction-driven SPI transmit sequencer for the display path. It fetches instruction words from the program store, shifts command and data words out on MOSI with the matching chip-select and data/command levels, and executes delay and halt instructions. It sits between the instruction memory and program counter (driven by `pcEn`) and the SCLK divider (which supplies `sclkEdge`). It generalises the earlier fixed 18-bit write-command/write-data/delay state machine with configurable word width, bit order, inter-word CS gap, an explicit fetch handshake, and a halt instruction.

---
 rtl/spi_seq_pkg.sv | 18 +
 rtl/spi_tx_shifter.sv | 39 +++
 rtl/spi_display_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared opcodes and FSM state encoding for the display SPI sequencer.
package spi_seq_pkg;

  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_DATA  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_GAP,
    S_DELAY,
    S_HALT
  } state_t;

endpackage

// File: rtl/spi_tx_shifter.sv
// Loadable transmit shift register with bit counter and last-bit flag.
module spi_tx_shifter #(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_adv,
  output logic              o_bit,
  output logic              o_last
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_sh;
  logic [CW-1:0]     r_cnt;

  // Zeros shift in behind the word, so the line idles low once it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= '0;
    end else if (i_adv) begin
      r_sh <= MSB_FIRST ? {r_sh[DATA_W-2:0], 1'b0}
                        : {1'b0, r_sh[DATA_W-1:1]};
      if (r_cnt != CW'(DATA_W))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit  = MSB_FIRST ? r_sh[DATA_W-1] : r_sh[0];
  assign o_last = (r_cnt == CW'(DATA_W - 1));

endmodule

// File: rtl/spi_display_sequencer.sv
// Instruction-driven SPI transmit sequencer: CMD/DATA shifts,
// sclkEdge-timed delays, halt, and an inter-word chip-select gap.
module spi_display_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int INSTR_W   = DATA_W + 2,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CS_GAP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               sclkEdge,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               pcEn,
  output logic               cs,
  output logic               dc,
  output logic               mosi,
  output logic               busy,
  output logic               done
);

  localparam int GW = $clog2(CS_GAP + 2);

  state_t            r_state;
  logic              r_cs;
  logic              r_dc;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_dcnt;
  logic [GW-1:0]     r_gcnt;

  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_payload;
  logic              w_accept;
  logic              w_load;
  logic              w_adv;
  logic              w_last;
  state_t            w_nxt;

  assign w_op      = instr[INSTR_W-1 -: 2];
  assign w_payload = instr[DATA_W-1:0];
  assign w_accept  = (r_state == S_FETCH) && run && instr_valid;
  assign w_load    = w_accept && !w_op[1];
  assign w_adv     = (r_state == S_SHIFT) && sclkEdge;
  assign w_nxt     = run ? S_FETCH : S_IDLE;

  spi_tx_shifter #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_data (w_payload),
    .i_adv  (w_adv),
    .o_bit  (mosi),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cs    <= 1'b1;
      r_dc    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dcnt  <= '0;
      r_gcnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!run) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (instr_valid) begin
            unique case (w_op)
              OP_CMD, OP_DATA: begin
                r_state <= S_SHIFT;
                r_cs    <= 1'b0;
                r_dc    <= w_op[0];
              end
              OP_DELAY: begin
                r_state <= S_DELAY;
                r_dcnt  <= w_payload;
              end
              default: begin
                r_state <= S_HALT;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            endcase
          end
        end
        S_SHIFT: begin
          if (sclkEdge && w_last) begin
            r_cs <= 1'b1;
            if (CS_GAP > 0) begin
              r_state <= S_GAP;
              r_gcnt  <= '0;
            end else begin
              r_state <= w_nxt;
              r_busy  <= run;
            end
          end
        end
        S_GAP: begin
          if (sclkEdge) begin
            if (r_gcnt == GW'(CS_GAP - 1)) begin
              r_state <= w_nxt;
              r_busy  <= run;
            end else begin
              r_gcnt <= r_gcnt + 1'b1;
            end
          end
        end
        S_DELAY: begin
          // Zero count leaves at once; otherwise exit on the final pulse.
          if (r_dcnt == '0) begin
            r_state <= w_nxt;
            r_busy  <= run;
          end else if (sclkEdge) begin
            r_dcnt <= r_dcnt - 1'b1;
            if (r_dcnt == DATA_W'(1)) begin
              r_state <= w_nxt;
              r_busy  <= run;
            end
          end
        end
        S_HALT: begin
          if (!run) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cs    <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign pcEn = w_accept;
  assign cs   = r_cs;
  assign dc   = r_dc;
  assign busy = r_busy;
  assign done = r_done;

endmodule
